pwm_sequencer: RTL and testbench
================================

# pwm_sequencer

Frame-based scheduler that drives the configuration inputs of `pwm_peripheral` (`en_reg_out_*`, `en_reg_pwm_*`, `pwm_duty_cycle`). It holds a small table of output frames and steps through them on a prescaled time base, one-shot or looping. It sits between the host register interface, which writes frames and issues start/stop, and the PWM peripheral, replacing static register drive with timed sequences.

## Interface
- `DEPTH`, default 4: number of frames in the table; power of 2, 2..16.
- `IW`, default `$clog2(DEPTH)`: frame index width.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  single-cycle table write strobe.
- `wr_frame`  in  IW  frame being written.
- `wr_field`  in  3  field select:
  - 0 `en_out[7:0]`, 1 `en_out[15:8]`, 2 `en_pwm[7:0]`, 3 `en_pwm[15:8]`, 4 `duty`, 5 `hold`.
  - 6 and 7 are ignored.
- `wr_data`  in  8  field value.
- `start`  in  1  begin sequence at frame 0. Level-sampled; acts only in IDLE.
- `stop`  in  1  abort sequence. Sampled every cycle.
- `loop`  in  1  level: wrap to frame 0 after `last_frame` instead of finishing.
- `last_frame`  in  IW  index of final frame in sequence.
- `tick_div`  in  16  prescaler: one tick every `tick_div+1` cycles.
- `en_reg_out_7_0`, `en_reg_out_15_8`, `en_reg_pwm_7_0`, `en_reg_pwm_15_8`, `pwm_duty_cycle`  out  8 each  registered drive to `pwm_peripheral`.
- `busy`  out  1  high in LOAD or HOLD.
- `done`  out  1  one-cycle pulse on non-looping completion.
- `frame_idx`  out  IW  frame currently applied.

## Operation
- **Table:** `DEPTH` × 6 bytes; all bytes reset to 0.
  - Writes are accepted in every state, one byte per cycle.
  - A write to the frame currently being shown does not change the outputs until that frame is next loaded.
- **States:** IDLE, LOAD, HOLD.
- **IDLE:**
  - Outputs hold their values.
  - `start`=1 and `stop`=0 → LOAD with `frame_idx`=0.
- **LOAD** (always 1 cycle):
  - Copies the frame's five config bytes to the outputs.
  - Sets `hold_cnt` = `hold`.
  - Clears the prescaler.
  - → HOLD.
- **HOLD:**
  - The prescaler counts 0..`tick_div`; `tick` fires when count == `tick_div`, then the count wraps to 0.
  - On `tick` with `hold_cnt`≠0: decrement `hold_cnt`.
  - On `tick` with `hold_cnt`=0 and `frame_idx`≠`last_frame`: `frame_idx`+1 → LOAD.
  - On `tick` with `hold_cnt`=0 and `frame_idx`=`last_frame`:
    - `loop`=1 → `frame_idx`=0 → LOAD.
    - `loop`=0 → IDLE, `done`=1 for one cycle, outputs retained.
- **stop:**
  - In LOAD or HOLD → IDLE next cycle.
  - All five config outputs are cleared to 0 (PWM safe-off), `frame_idx`=0, no `done`.
  - In IDLE, `stop` also clears the outputs.
- **Simultaneous events:**
  - `start` and `stop` in the same cycle: `stop` wins.
  - `start` while busy is ignored.
  - `wr_en` coincident with LOAD of the same frame: LOAD uses the old value.
- **Out-of-range `last_frame`:** `last_frame` ≥ `DEPTH` cannot occur because the port is IW bits wide. `last_frame`=0 gives a single-frame sequence.
- **Reset** (any time, including mid-sequence):
  - State IDLE; all outputs, `busy`, `done`, `frame_idx`, counters and table = 0.

## Timing
- `start` sampled high at edge N: LOAD during cycle N+1, outputs updated at edge N+2, `busy`=1 from edge N+1.
- Each frame occupies 1 LOAD cycle plus (`hold`+1)×(`tick_div`+1) HOLD cycles.
- `tick_div`=0 means a tick every cycle.
- Config outputs change only at the edge that ends LOAD, or on stop/reset.
- `done` is asserted on the edge entering IDLE; `busy` falls on that same edge.
- `stop` has 1-cycle latency to outputs=0.

## Configuration
- `PWM_SEQ_RAMP_EN` defined:
  - LOAD does not update `pwm_duty_cycle`. It latches the frame's duty as `duty_tgt`.
  - Every HOLD tick moves `pwm_duty_cycle` 1 LSB toward `duty_tgt`, saturating at `duty_tgt`.
  - The frame advances on schedule even if the target has not been reached.
  - Enable bytes still update at LOAD. `stop` and reset still force duty to 0 immediately.
- Not defined: duty updates at LOAD like the other four bytes; no `duty_tgt` register exists.

## Test plan
- Reset → all outputs 0, `busy`=0. Write frame 0 = {FF, 00, 0F, 00, duty 80, hold 2}, `tick_div`=3, `last_frame`=0, pulse `start` → outputs FF/00/0F/00/80 two cycles after start; `done` exactly 1+3×4=13 cycles after LOAD; outputs retained.
- Frames 0..2 with hold 0, `tick_div`=0, `loop`=1 → `frame_idx` sequence 0,1,2,0,1 with a 2-cycle period per frame.
- Assert `stop` mid-HOLD → next cycle all config outputs 0, `busy`=0, no `done`. `start`+`stop` together in IDLE → remains IDLE.
- Assert `rst` asynchronously mid-sequence → outputs 0 without a clock edge; table reads back 0 (a fresh start outputs zeros).
- Write frame 1 duty while frame 1 is displayed → outputs unchanged; new value appears on the next loop pass.
- `PWM_SEQ_RAMP_EN`: frame 0 duty 0 → frame 1 duty 5, hold 9, `tick_div`=0 → duty 1,2,3,4,5 on successive ticks, then holds at 5.

Source files
------------

// File: rtl/pwm_sequencer.sv
// Frame-table sequencer driving pwm_peripheral config bytes on a prescaled time base.
// Optional PWM_SEQ_RAMP_EN: duty slews 1 LSB per tick toward the frame target instead of stepping at LOAD.
module pwm_sequencer #(
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_frame,
  input  logic [2:0]    wr_field,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [IW-1:0] last_frame,
  input  logic [15:0]   tick_div,
  output logic [7:0]    en_reg_out_7_0,
  output logic [7:0]    en_reg_out_15_8,
  output logic [7:0]    en_reg_pwm_7_0,
  output logic [7:0]    en_reg_pwm_15_8,
  output logic [7:0]    pwm_duty_cycle,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] frame_idx
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [DEPTH-1:0][5:0][7:0] tbl_q, tbl_d;
  logic [15:0]               en_out_q, en_out_d;
  logic [15:0]               en_pwm_q, en_pwm_d;
  logic [7:0]                duty_q, duty_d;
  logic [7:0]                hold_q, hold_d;
  logic [15:0]               pre_q, pre_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      done_q, done_d;
  logic                      tick;
`ifdef PWM_SEQ_RAMP_EN
  logic [7:0]                tgt_q, tgt_d;
`endif

  assign tick = (pre_q == tick_div);

  always_comb begin
    state_d  = state_q;
    tbl_d    = tbl_q;
    en_out_d = en_out_q;
    en_pwm_d = en_pwm_q;
    duty_d   = duty_q;
    hold_d   = hold_q;
    pre_d    = pre_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
`ifdef PWM_SEQ_RAMP_EN
    tgt_d    = tgt_q;
`endif
    // Table writes land at the edge, so a same-cycle LOAD still sees the old byte.
    if (wr_en && wr_field <= 3'd5)
      tbl_d[wr_frame][wr_field] = wr_data;

    if (stop) begin
      state_d  = IDLE;
      en_out_d = '0;
      en_pwm_d = '0;
      duty_d   = '0;
      idx_d    = '0;
`ifdef PWM_SEQ_RAMP_EN
      tgt_d    = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end
        LOAD: begin
          en_out_d = {tbl_q[idx_q][1], tbl_q[idx_q][0]};
          en_pwm_d = {tbl_q[idx_q][3], tbl_q[idx_q][2]};
`ifdef PWM_SEQ_RAMP_EN
          tgt_d    = tbl_q[idx_q][4];
`else
          duty_d   = tbl_q[idx_q][4];
`endif
          hold_d   = tbl_q[idx_q][5];
          pre_d    = '0;
          state_d  = HOLD;
        end
        HOLD: begin
          if (tick) begin
            pre_d = '0;
`ifdef PWM_SEQ_RAMP_EN
            if (duty_q < tgt_q)      duty_d = duty_q + 8'd1;
            else if (duty_q > tgt_q) duty_d = duty_q - 8'd1;
`endif
            if (hold_q != 8'd0) begin
              hold_d = hold_q - 8'd1;
            end else if (idx_q != last_frame) begin
              idx_d   = idx_q + 1'b1;
              state_d = LOAD;
            end else if (loop) begin
              idx_d   = '0;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tbl_q    <= '0;
      en_out_q <= '0;
      en_pwm_q <= '0;
      duty_q   <= '0;
      hold_q   <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
      tgt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tbl_q    <= tbl_d;
      en_out_q <= en_out_d;
      en_pwm_q <= en_pwm_d;
      duty_q   <= duty_d;
      hold_q   <= hold_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
`ifdef PWM_SEQ_RAMP_EN
      tgt_q    <= tgt_d;
`endif
    end
  end

  assign en_reg_out_7_0  = en_out_q[7:0];
  assign en_reg_out_15_8 = en_out_q[15:8];
  assign en_reg_pwm_7_0  = en_pwm_q[7:0];
  assign en_reg_pwm_15_8 = en_pwm_q[15:8];
  assign pwm_duty_cycle  = duty_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign frame_idx       = idx_q;
endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed vector bench for pwm_sequencer: one-shot, looping, stop, write-while-shown, async reset, ramp.
module tb_pwm_sequencer;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_frame;
  logic [2:0]    wr_field;
  logic [7:0]    wr_data;
  logic          start, stop, loop;
  logic [IW-1:0] last_frame;
  logic [15:0]   tick_div;
  logic [7:0]    en_out_7_0, en_out_15_8, en_pwm_7_0, en_pwm_15_8, duty;
  logic          busy, done;
  logic [IW-1:0] frame_idx;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pwm_sequencer #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_frame(wr_frame), .wr_field(wr_field),
    .wr_data(wr_data), .start(start), .stop(stop), .loop(loop), .last_frame(last_frame),
    .tick_div(tick_div), .en_reg_out_7_0(en_out_7_0), .en_reg_out_15_8(en_out_15_8),
    .en_reg_pwm_7_0(en_pwm_7_0), .en_reg_pwm_15_8(en_pwm_15_8), .pwm_duty_cycle(duty),
    .busy(busy), .done(done), .frame_idx(frame_idx)
  );

  typedef struct {
    logic          we;
    logic [IW-1:0] wf;
    logic [2:0]    fld;
    logic [7:0]    wd;
    logic          st, sp, lp;
    logic [IW-1:0] last;
    logic [15:0]   td;
    int            n;
    logic [15:0]   eo, ep;
    logic [7:0]    ed;
    logic          eb, edn;
    logic [IW-1:0] efi;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic we, input logic [IW-1:0] wf, input logic [2:0] fld,
                     input logic [7:0] wd, input logic st, sp, lp, input logic [IW-1:0] last,
                     input logic [15:0] td, input int n, input logic [15:0] eo, ep,
                     input logic [7:0] ed, input logic eb, edn, input logic [IW-1:0] efi);
    vec_t v;
    v.we = we; v.wf = wf; v.fld = fld; v.wd = wd; v.st = st; v.sp = sp; v.lp = lp;
    v.last = last; v.td = td; v.n = n; v.eo = eo; v.ep = ep; v.ed = ed; v.eb = eb;
    v.edn = edn; v.efi = efi;
    tv.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] eo, ep, input logic [7:0] ed,
                       input logic eb, edn, input logic [IW-1:0] efi);
    nvec++;
    if ({en_out_15_8, en_out_7_0} !== eo || {en_pwm_15_8, en_pwm_7_0} !== ep ||
        duty !== ed || busy !== eb || done !== edn || frame_idx !== efi) begin
      nerr++;
      $display("FAIL %s: got out=%h pwm=%h duty=%h busy=%b done=%b idx=%0d, want out=%h pwm=%h duty=%h busy=%b done=%b idx=%0d",
               nm, {en_out_15_8, en_out_7_0}, {en_pwm_15_8, en_pwm_7_0}, duty, busy, done,
               frame_idx, eo, ep, ed, eb, edn, efi);
    end
  endtask

  task automatic drive(input vec_t v);
    wr_en = v.we; wr_frame = v.wf; wr_field = v.fld; wr_data = v.wd;
    start = v.st; stop = v.sp; loop = v.lp; last_frame = v.last; tick_div = v.td;
  endtask

  task automatic wr(input logic [IW-1:0] f, input logic [2:0] fld, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_frame = f; wr_field = fld; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_frame = 0; wr_field = 0; wr_data = 0;
    start = 0; stop = 0; loop = 0; last_frame = 0; tick_div = 0;
    #12;
    check("reset", 16'h0, 16'h0, 8'h0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

`ifndef PWM_SEQ_RAMP_EN
    // one-shot: frame 0 = {FF,00,0F,00,80,hold 2}, tick_div 3
    add(1,0,0,8'hFF, 0,0,0,0,3, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(1,0,1,8'h00, 0,0,0,0,3, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(1,0,2,8'h0F, 0,0,0,0,3, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(1,0,3,8'h00, 0,0,0,0,3, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(1,0,4,8'h80, 0,0,0,0,3, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(1,0,5,8'h02, 0,0,0,0,3, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(1,0,6,8'h77, 0,0,0,0,3, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(0,0,0,8'h00, 1,0,0,0,3, 1, 16'h0000,16'h0000,8'h00, 1,0,0);
    add(0,0,0,8'h00, 0,0,0,0,3, 1, 16'h00FF,16'h000F,8'h80, 1,0,0);
    add(0,0,0,8'h00, 0,0,0,0,3,11, 16'h00FF,16'h000F,8'h80, 1,0,0);
    add(0,0,0,8'h00, 0,0,0,0,3, 1, 16'h00FF,16'h000F,8'h80, 0,1,0);
    add(0,0,0,8'h00, 0,0,0,0,3, 1, 16'h00FF,16'h000F,8'h80, 0,0,0);
    // loop over frames 0..2, hold 0, tick_div 0
    add(1,0,5,8'h00, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 0,0,0);
    add(1,1,0,8'h01, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 0,0,0);
    add(1,1,4,8'h11, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 0,0,0);
    add(1,2,0,8'h02, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 0,0,0);
    add(1,2,4,8'h22, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 0,0,0);
    add(0,0,0,8'h00, 1,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 1,0,0);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 1,0,0);
    add(0,0,0,8'h00, 1,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 1,0,1);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h0001,16'h0000,8'h11, 1,0,1);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h0001,16'h0000,8'h11, 1,0,2);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h0002,16'h0000,8'h22, 1,0,2);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h0002,16'h0000,8'h22, 1,0,0);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 1,0,0);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 1,0,1);
    // write frame 1 duty on the LOAD edge of frame 1: old value shown this pass
    add(1,1,4,8'h55, 0,0,1,2,0, 1, 16'h0001,16'h0000,8'h11, 1,0,1);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h0001,16'h0000,8'h11, 1,0,2);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h0002,16'h0000,8'h22, 1,0,2);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h0002,16'h0000,8'h22, 1,0,0);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 1,0,0);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h00FF,16'h000F,8'h80, 1,0,1);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h0001,16'h0000,8'h55, 1,0,1);
    // stop mid-HOLD, then start+stop together in IDLE
    add(0,0,0,8'h00, 0,1,1,2,0, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(0,0,0,8'h00, 0,0,1,2,0, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(0,0,0,8'h00, 1,1,1,2,0, 1, 16'h0000,16'h0000,8'h00, 0,0,0);
    add(0,0,0,8'h00, 0,0,1,2,0, 2, 16'h0000,16'h0000,8'h00, 0,0,0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      repeat (tv[i].n) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tv[i].eo, tv[i].ep, tv[i].ed, tv[i].eb, tv[i].edn, tv[i].efi);
    end

    // async reset mid-sequence, then a fresh start must show an all-zero table
    @(negedge clk);
    wr_en = 0; start = 1; stop = 0; loop = 1; last_frame = 2; tick_div = 0;
    @(negedge clk);
    start = 0;
    @(posedge clk); #1;
    check("pre_rst_frame0", 16'h00FF, 16'h000F, 8'h80, 1'b1, 1'b0, 2'd0);
    #2 rst = 1'b1;
    #1 check("async_rst", 16'h0, 16'h0, 8'h0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(posedge clk);
    #1 check("post_rst_table0", 16'h0, 16'h0, 8'h0, 1'b1, 1'b0, 2'd1);
`else
    // ramp: frame 0 duty 0 hold 0, frame 1 duty 5 hold 9, tick_div 0
    wr(2'd0, 3'd0, 8'hA5);
    wr(2'd1, 3'd4, 8'h05);
    wr(2'd1, 3'd5, 8'h09);
    @(negedge clk);
    loop = 0; last_frame = 1; tick_div = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(posedge clk); #1;
    check("ramp_load0", 16'h00A5, 16'h0, 8'd0, 1'b1, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1 check("ramp_load1", 16'h0000, 16'h0, 8'd0, 1'b1, 1'b0, 2'd1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("ramp_t%0d", k), 16'h0000, 16'h0, (k > 5) ? 8'd5 : 8'(k), 1'b1, 1'b0, 2'd1);
    end
    repeat (4) @(posedge clk);
    #1 check("ramp_done", 16'h0000, 16'h0, 8'd5, 1'b0, 1'b1, 2'd1);
    @(negedge clk);
    stop = 1;
    @(posedge clk); #1;
    check("ramp_stop", 16'h0000, 16'h0, 8'd0, 1'b0, 1'b0, 2'd0);
    stop = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
